// File: rtl/cnn_pkg.sv
// Shared CNN block definitions: pooling FSM states and output-size helper.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DRAIN  = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } pool_state_e;

  // Number of window positions along one side of the feature map.
  function automatic int unsigned pool_out_dim(input int unsigned in_dim,
                                               input int unsigned pool,
                                               input int unsigned stride);
    return (in_dim - pool) / stride + 1;
  endfunction

endpackage

// File: rtl/pool_ctrl_if.sv
// Memory-side bus of the pooling controller: input-map reads and result writes.
interface pool_ctrl_if #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WIDTH_BIT = 16
) ();

  logic                        rd_en;
  logic [ADDR_W-1:0]           rd_addr;
  logic signed [WIDTH_BIT-1:0] rd_data;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic signed [WIDTH_BIT-1:0] wr_data;

  modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);

endinterface

// File: rtl/pool_addr_gen.sv
// Window / element counters and registered read/write address generation.
// Counters always hold the next element to issue and the current window.
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int unsigned IN_DIM = 28,
  parameter int unsigned POOL   = 2,
  parameter int unsigned STRIDE = 2,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              clear,
  input  logic              issue,
  input  logic              win_adv,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              elem_zero_c,
  output logic              win_zero_c
);

  localparam int unsigned OUT_DIM = pool_out_dim(IN_DIM, POOL, STRIDE);

  logic [ADDR_W-1:0] erow_q, erow_d;
  logic [ADDR_W-1:0] ecol_q, ecol_d;
  logic [ADDR_W-1:0] orow_q, orow_d;
  logic [ADDR_W-1:0] ocol_q, ocol_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  always_comb begin
    erow_d    = erow_q;
    ecol_d    = ecol_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    if (clear) begin
      erow_d = '0;
      ecol_d = '0;
      orow_d = '0;
      ocol_d = '0;
    end else begin
      // Row-major walk inside the window; wraps to element 0 after the last.
      if (issue) begin
        rd_addr_d = (orow_q * ADDR_W'(STRIDE) + erow_q) * ADDR_W'(IN_DIM)
                  + ocol_q * ADDR_W'(STRIDE) + ecol_q;
        if (ecol_q == ADDR_W'(POOL - 1)) begin
          ecol_d = '0;
          erow_d = (erow_q == ADDR_W'(POOL - 1)) ? '0 : erow_q + 1'b1;
        end else begin
          ecol_d = ecol_q + 1'b1;
        end
      end
      // Latch the result address, then step column-first to the next window.
      if (win_adv) begin
        wr_addr_d = orow_q * ADDR_W'(OUT_DIM) + ocol_q;
        if (ocol_q == ADDR_W'(OUT_DIM - 1)) begin
          ocol_d = '0;
          orow_d = (orow_q == ADDR_W'(OUT_DIM - 1)) ? '0 : orow_q + 1'b1;
        end else begin
          ocol_d = ocol_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      erow_q    <= '0;
      ecol_q    <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      erow_q    <= erow_d;
      ecol_q    <= ecol_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign wr_addr     = wr_addr_q;
  assign elem_zero_c = (erow_q == '0) && (ecol_q == '0);
  assign win_zero_c  = (orow_q == '0) && (ocol_q == '0);

endmodule

// File: rtl/pool_ctrl.sv
// Max-pooling controller: reads each window, keeps a signed running max,
// writes one result per window and pulses done after the last one.
module pool_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned IN_DIM    = 28,
  parameter int unsigned POOL      = 2,
  parameter int unsigned STRIDE    = 2,
  parameter int unsigned WIDTH_BIT = 16,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  pool_ctrl_if.master mem
);

  pool_state_e state_q, state_d;

  logic rd_en_q, rd_en_d;
  logic wr_en_q, wr_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic rd_vld_q, rd_vld_d;
  logic rd_first_q, rd_first_d;
  logic signed [WIDTH_BIT-1:0] max_q, max_d;
  logic signed [WIDTH_BIT-1:0] wr_data_q, wr_data_d;

  logic              abort_act_c;
  logic              elem_zero_c;
  logic              win_zero_c;
  logic [ADDR_W-1:0] gen_rd_addr;
  logic [ADDR_W-1:0] gen_wr_addr;

  pool_addr_gen #(
    .IN_DIM (IN_DIM),
    .POOL   (POOL),
    .STRIDE (STRIDE),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock       (clock),
    .nreset      (nreset),
    .clear       (abort_act_c),
    .issue       (rd_en_d),
    .win_adv     (wr_en_d),
    .rd_addr     (gen_rd_addr),
    .wr_addr     (gen_wr_addr),
    .elem_zero_c (elem_zero_c),
    .win_zero_c  (win_zero_c)
  );

  // Next state, running max and registered output values.
  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    wr_data_d   = wr_data_q;
    abort_act_c = abort && (state_q != IDLE);

    if (abort_act_c) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = FETCH;
        FETCH:   if (elem_zero_c) state_d = DRAIN;
        DRAIN:   state_d = WRITE;
        WRITE:   state_d = win_zero_c ? FINISH : FETCH;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Data returns one cycle after each read; the first of a window seeds the max.
    if (rd_vld_q && !abort_act_c && (rd_first_q || (mem.rd_data > max_q))) begin
      max_d = mem.rd_data;
    end
    rd_vld_d   = (state_q == FETCH) && !abort_act_c;
    rd_first_d = (state_q == FETCH) && !rd_vld_q && !abort_act_c;

    rd_en_d = (state_d == FETCH);
    wr_en_d = (state_d == WRITE);
    done_d  = (state_d == FINISH);
    busy_d  = (state_d != IDLE);
    if (state_d == WRITE) wr_data_d = max_d;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      max_q      <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_vld_q   <= rd_vld_d;
      rd_first_q <= rd_first_d;
      max_q      <= max_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = gen_rd_addr;
  assign mem.wr_en   = wr_en_q;
  assign mem.wr_addr = gen_wr_addr;
  assign mem.wr_data = wr_data_q;

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl with a behavioural read memory and write monitor.
module tb_pool_ctrl;

  localparam int DIM  = 28;
  localparam int ODIM = 14;

  typedef struct {
    logic signed [15:0] v0;
    logic signed [15:0] v1;
    logic signed [15:0] v2;
    logic signed [15:0] v3;
    logic signed [15:0] exp_max;
  } vec_t;

  logic clock;
  logic nreset;
  logic start;
  logic abort;
  logic busy;
  logic done;

  pool_ctrl_if mem_if ();

  pool_ctrl dut (
    .clock  (clock),
    .nreset (nreset),
    .start  (start),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .mem    (mem_if)
  );

  logic signed [15:0] mem_arr [1024];
  logic signed [15:0] out_arr [1024];
  int wr_count;
  int rd_count;
  int done_cnt;
  int rd_before_wr;
  int rd_log [$];
  logic clr_mon;

  int n_tests;
  int n_fail;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    mem_if.rd_data <= mem_if.rd_en ? mem_arr[mem_if.rd_addr] : 16'sd0;
  end

  always @(posedge clock) begin
    if (clr_mon) begin
      wr_count     = 0;
      rd_count     = 0;
      done_cnt     = 0;
      rd_before_wr = 0;
      rd_log.delete();
      for (int i = 0; i < 1024; i++) out_arr[i] = 16'sd0;
    end else begin
      if (mem_if.rd_en) begin
        rd_count++;
        if (wr_count == 0) rd_before_wr++;
        if (rd_log.size() < 8) rd_log.push_back(int'(mem_if.rd_addr));
      end
      if (mem_if.wr_en) begin
        out_arr[mem_if.wr_addr] = mem_if.wr_data;
        wr_count++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic clear_mon();
    @(negedge clock);
    clr_mon = 1'b1;
    @(posedge clock);
    #1 clr_mon = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        mem_arr[r*DIM+c] = 16'(r*DIM+c);
  endtask

  // Pulses start, then counts cycles until done; poke re-pulses start mid-map.
  task automatic run_to_done(input int budget, input int poke, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1;
    while (cyc <= budget && !ok) begin
      if (done) ok = 1'b1;
      else begin
        start = (cyc == poke);
        @(posedge clock);
        #1 cyc++;
      end
    end
    start = 1'b0;
  endtask

  vec_t vecs [8];
  int   cyc;
  bit   ok;
  int   bad;
  int   w0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    start   = 1'b0;
    abort   = 1'b0;
    clr_mon = 1'b0;
    nreset  = 1'b1;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 16'sd0;

    vecs[0] = '{-16'sd5, -16'sd3, -16'sd8, -16'sd1, -16'sd1};
    vecs[1] = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
    vecs[2] = '{16'sd7, 16'sd7, 16'sd2, 16'sd7, 16'sd7};
    vecs[3] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd4};
    vecs[4] = '{16'sd4, 16'sd3, 16'sd2, 16'sd1, 16'sd4};
    vecs[5] = '{16'sh7FFF, 16'sh8000, 16'sd0, 16'sd1, 16'sh7FFF};
    vecs[6] = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4, -16'sd1};
    vecs[7] = '{16'sd0, 16'sd0, 16'sd0, -16'sd1, 16'sd0};

    #2 nreset = 1'b0;
    #1;
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_rd_en", longint'(mem_if.rd_en), 0);
    check("rst_wr_en", longint'(mem_if.wr_en), 0);
    check("rst_rd_addr", longint'(mem_if.rd_addr), 0);
    check("rst_wr_addr", longint'(mem_if.wr_addr), 0);
    check("rst_wr_data", longint'(mem_if.wr_data), 0);
    repeat (2) @(posedge clock);
    @(negedge clock) nreset = 1'b1;

    // Full ramp map with a start pulse injected while busy.
    fill_ramp();
    clear_mon();
    run_to_done(2000, 100, cyc, ok);
    check("ramp_done_seen", longint'(ok), 1);
    check("ramp_done_cycle", cyc, 1177);
    @(posedge clock);
    #1;
    check("ramp_busy_after", longint'(busy), 0);
    check("ramp_writes", wr_count, 196);
    check("ramp_reads", rd_count, 784);
    check("ramp_done_pulses", done_cnt, 1);
    check("ramp_addr0", longint'(out_arr[0]), 29);
    check("ramp_addr195", longint'(out_arr[195]), 783);
    check("ramp_addr13", longint'(out_arr[13]), 55);
    bad = 0;
    for (int r = 0; r < ODIM; r++)
      for (int c = 0; c < ODIM; c++)
        if (int'(out_arr[r*ODIM+c]) != (2*r+1)*DIM + 2*c + 1) bad++;
    check("ramp_all_windows", bad, 0);
    check("win0_read_cycles", rd_before_wr, 4);
    check("rd_log_len", rd_log.size(), 8);
    if (rd_log.size() >= 4) begin
      check("rd_addr_0", rd_log[0], 0);
      check("rd_addr_1", rd_log[1], 1);
      check("rd_addr_2", rd_log[2], 28);
      check("rd_addr_3", rd_log[3], 29);
    end

    // Vector table: vector k placed in window (0,k), rest of the map zero.
    for (int i = 0; i < 1024; i++) mem_arr[i] = 16'sd0;
    for (int k = 0; k < 8; k++) begin
      mem_arr[2*k]       = vecs[k].v0;
      mem_arr[2*k+1]     = vecs[k].v1;
      mem_arr[DIM+2*k]   = vecs[k].v2;
      mem_arr[DIM+2*k+1] = vecs[k].v3;
    end
    clear_mon();
    run_to_done(2000, -1, cyc, ok);
    check("vec_done_seen", longint'(ok), 1);
    check("vec_writes", wr_count, 196);
    for (int k = 0; k < 8; k++)
      check($sformatf("vec%0d_max", k), longint'(out_arr[k]), longint'(vecs[k].exp_max));

    // Abort on the third read of window 5, then restart from window 0.
    fill_ramp();
    clear_mon();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1;
    while (cyc < 33) begin
      @(posedge clock);
      #1 cyc++;
    end
    check("abort_in_fetch", longint'(mem_if.rd_en), 1);
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    check("abort_busy", longint'(busy), 0);
    check("abort_rd_en", longint'(mem_if.rd_en), 0);
    check("abort_wr_en", longint'(mem_if.wr_en), 0);
    repeat (10) @(posedge clock);
    #1;
    check("abort_writes", wr_count, 5);
    check("abort_no_done", done_cnt, 0);
    clear_mon();
    run_to_done(2000, -1, cyc, ok);
    check("restart_cycle", cyc, 1177);
    check("restart_writes", wr_count, 196);
    w0 = (rd_log.size() > 0) ? rd_log[0] : -1;
    check("restart_first_rd", w0, 0);
    check("restart_addr0", longint'(out_arr[0]), 29);

    // Reset during the first WRITE cycle.
    clear_mon();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 0;
    while (!mem_if.wr_en && cyc < 20) begin
      @(posedge clock);
      #1 cyc++;
    end
    check("reach_write", longint'(mem_if.wr_en), 1);
    @(negedge clock);
    nreset = 1'b0;
    #1;
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_wr_en", longint'(mem_if.wr_en), 0);
    check("mid_rst_rd_en", longint'(mem_if.rd_en), 0);
    check("mid_rst_wr_data", longint'(mem_if.wr_data), 0);
    check("mid_rst_wr_addr", longint'(mem_if.wr_addr), 0);
    @(posedge clock);
    #1;
    check("mid_rst_no_write", wr_count, 0);
    @(negedge clock) nreset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("post_rst_idle", longint'(busy), 0);
    check("post_rst_writes", wr_count, 0);
    clear_mon();
    run_to_done(2000, -1, cyc, ok);
    check("post_rst_run_writes", wr_count, 196);
    check("post_rst_addr195", longint'(out_arr[195]), 783);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
